// File: rtl/hs_pkg.sv
// hs_pkg: shared types and default constants for the handshake pipeline arbiter.
//   hs_arb_state_t : arbiter FSM states
//   HS_W           : default data width of the pipeline data path
//   HS_SYNC        : default flop count of the ack synchronizer
//   HS_TIMEOUT     : default watchdog limit (cycles per handshake phase)
package hs_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PH_UP = 3'd2,
    PH_DN = 3'd3,
    ERR   = 3'd4
  } hs_arb_state_t;

  localparam int HS_W       = 16;
  localparam int HS_SYNC    = 2;
  localparam int HS_TIMEOUT = 64;

endpackage

// File: rtl/hs_sync.sv
// hs_sync: STAGES-flop single-bit synchronizer, synchronous reset to 0.
//   clk  : destination clock
//   rst  : synchronous active-high reset (clears every flop)
//   i_d  : asynchronous input bit
//   o_q  : synchronized output (last flop of the chain)
module hs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/hs_pipe_arbiter.sv
// hs_pipe_arbiter: round-robin arbiter feeding a four-phase bundled-data
// pipeline input from N clocked requesters.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   req       : [N] level requests, held until the matching done pulse
//   data      : [N*W] requester words, slice i = data[i*W +: W]
//   done      : [N] one-cycle completion pulse to the served requester
//   grant_id  : index of the current / last granted requester
//   busy      : high whenever the FSM is not in IDLE
//   pipe_req  : registered pipeline in_req
//   pipe_data : registered pipeline in_data
//   pipe_ack  : pipeline out_ack, asynchronous to clk
//   err       : sticky watchdog flag, cleared only by rst
module hs_pipe_arbiter
  import hs_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = HS_W,
  parameter int SYNC_STAGES = HS_SYNC,
  parameter int TIMEOUT     = HS_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data,
  output logic [N-1:0]         done,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 pipe_req,
  output logic [W-1:0]         pipe_data,
  input  logic                 pipe_ack,
  output logic                 err
);

  localparam int IDX_W = $clog2(N);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  hs_arb_state_t    r_state, w_state_next;
  logic             r_pipe_req, w_pipe_req_next;
  logic [W-1:0]     r_pipe_data, w_pipe_data_next;
  logic [IDX_W-1:0] r_grant_id, w_grant_id_next;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_next;
  logic [WD_W-1:0]  r_wd_cnt, w_wd_cnt_next;
  logic [N-1:0]     r_done, w_done_next;
  logic             r_err, w_err_next;
  logic             w_ack_s;
  logic [IDX_W-1:0] w_winner;
  logic [W-1:0]     w_data_arr [N];

  hs_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pipe_ack),
    .o_q (w_ack_s)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign w_data_arr[gi] = data[gi*W +: W];
  end

  // First set bit at or after ptr, scanning cyclically.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] reqv,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && reqv[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_winner = rr_pick(req, r_rr_ptr);

  always_comb begin
    w_state_next     = r_state;
    w_pipe_req_next  = r_pipe_req;
    w_pipe_data_next = r_pipe_data;
    w_grant_id_next  = r_grant_id;
    w_rr_ptr_next    = r_rr_ptr;
    w_wd_cnt_next    = r_wd_cnt;
    w_done_next      = '0;
    w_err_next       = r_err;
    case (r_state)
      IDLE: begin
        // A high ack_s means the pipeline has not returned to zero yet.
        if ((|req) && !w_ack_s) begin
          w_state_next     = SETUP;
          w_pipe_data_next = w_data_arr[w_winner];
          w_grant_id_next  = w_winner;
        end
      end
      SETUP: begin
        // Data has been stable for a full cycle: safe to raise the request.
        w_state_next    = PH_UP;
        w_pipe_req_next = 1'b1;
        w_wd_cnt_next   = '0;
      end
      PH_UP: begin
        if (w_ack_s) begin
          w_state_next    = PH_DN;
          w_pipe_req_next = 1'b0;
          w_wd_cnt_next   = '0;
        end else if (r_wd_cnt == WD_MAX) begin
          w_state_next    = ERR;
          w_pipe_req_next = 1'b0;
          w_err_next      = 1'b1;
        end else begin
          w_wd_cnt_next = r_wd_cnt + 1'b1;
        end
      end
      PH_DN: begin
        if (!w_ack_s) begin
          w_state_next            = IDLE;
          w_done_next[r_grant_id] = 1'b1;
          w_rr_ptr_next           = (r_grant_id == LAST_IDX) ? '0 : r_grant_id + 1'b1;
        end else if (r_wd_cnt == WD_MAX) begin
          w_state_next = ERR;
          w_err_next   = 1'b1;
        end else begin
          w_wd_cnt_next = r_wd_cnt + 1'b1;
        end
      end
      ERR: begin
        w_pipe_req_next = 1'b0;
        w_err_next      = 1'b1;
      end
      default: begin
        w_state_next    = IDLE;
        w_pipe_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pipe_req  <= 1'b0;
      r_pipe_data <= '0;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_wd_cnt    <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pipe_req  <= w_pipe_req_next;
      r_pipe_data <= w_pipe_data_next;
      r_grant_id  <= w_grant_id_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_wd_cnt    <= w_wd_cnt_next;
      r_done      <= w_done_next;
      r_err       <= w_err_next;
    end
  end

  assign done      = r_done;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != IDLE);
  assign pipe_req  = r_pipe_req;
  assign pipe_data = r_pipe_data;
  assign err       = r_err;

endmodule

// File: tb/tb_hs_pipe_arbiter.sv
// tb_hs_pipe_arbiter: randomized and directed bench for hs_pipe_arbiter.
// Expected grant order comes from a transaction-level round-robin model:
// a batch of requests raised together is served in cyclic order from the
// model pointer, and the pointer moves past the last served requester.
module tb_hs_pipe_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int S  = 2;
  localparam int TO = 64;
  // Cycle offsets of an instant-pipeline transfer, counted from the edge
  // that samples req.
  localparam int RISE_C = 1;
  localparam int FALL_C = RISE_C + S + 1;
  localparam int DONE_C = FALL_C + S + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   done;
  logic [1:0]     grant_id;
  logic           busy;
  logic           pipe_req;
  logic [W-1:0]   pipe_data;
  logic           pipe_ack;
  logic           err;

  always #5 clk = ~clk;

  hs_pipe_arbiter #(.N(N), .W(W), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .done      (done),
    .grant_id  (grant_id),
    .busy      (busy),
    .pipe_req  (pipe_req),
    .pipe_data (pipe_data),
    .pipe_ack  (pipe_ack),
    .err       (err)
  );

  // Pipeline model: mode 0 = ack follows pipe_req after ack_dly cycles,
  // mode 1 = ack never rises, mode 2 = ack stuck high.
  logic [7:0] ack_hist = '0;
  logic [2:0] ack_dly  = '0;
  logic [1:0] ack_mode = '0;
  always @(posedge clk) ack_hist <= {ack_hist[6:0], pipe_req};
  assign pipe_ack = (ack_mode == 2'd1) ? 1'b0 :
                    (ack_mode == 2'd2) ? 1'b1 :
                    (ack_dly == 3'd0)  ? pipe_req : ack_hist[ack_dly - 3'd1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] word;
  } xfer_t;

  xfer_t      launch_q[$];
  logic [1:0] done_q[$];
  logic       prev_pipe_req = 1'b0;
  int         m_ptr = 0;

  // One clock, sampled on the falling edge; checks launches and done pulses
  // against the expected queues, and requesters drop req on their done.
  task automatic step();
    xfer_t      x;
    logic [1:0] di;
    @(negedge clk);
    if (pipe_req && !prev_pipe_req) begin
      if (launch_q.size() == 0) begin
        chk("launch_unexpected", 32'(pipe_req), 32'd0);
      end else begin
        x = launch_q.pop_front();
        chk("launch_grant_id", 32'(grant_id), 32'(x.idx));
        chk("launch_data", 32'(pipe_data), 32'(x.word));
        $display("[TB] launch grant=%0d data=%h", grant_id, pipe_data);
      end
    end
    prev_pipe_req = pipe_req;
    if (done != '0) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        di = done_q.pop_front();
        chk("done_onehot", 32'(done), 32'd1 << di);
        $display("[TB] done=%b", done);
      end
      req = req & ~done;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    req = '0;
    repeat (cycles) step();
    launch_q.delete();
    done_q.delete();
    m_ptr = 0;
    rst   = 1'b0;
  endtask

  // Round-robin model: serve the mask in cyclic order starting at m_ptr.
  task automatic plan(input logic [3:0] mask, input logic [63:0] words);
    xfer_t x;
    int    idx;
    int    last;
    last = m_ptr;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (mask[idx]) begin
        x.idx  = 2'(idx);
        x.word = words[idx*16 +: 16];
        launch_q.push_back(x);
        done_q.push_back(2'(idx));
        last = idx;
      end
    end
    m_ptr = (last + 1) % N;
  endtask

  task automatic drain(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while ((done_q.size() != 0 || launch_q.size() != 0) && cyc < budget) begin
      step();
      cyc++;
    end
    if (done_q.size() != 0 || launch_q.size() != 0) begin
      chk(tag, 32'(done_q.size() + launch_q.size()), 32'd0);
      launch_q.delete();
      done_q.delete();
      req = '0;
    end
  endtask

  task automatic run_batch(input logic [3:0] mask, input logic [63:0] words,
                           input logic [2:0] dly);
    ack_mode = 2'd0;
    ack_dly  = dly;
    plan(mask, words);
    data = words;
    req  = mask;
    drain("batch_complete", 40 * N);
    repeat (2) step();
    chk("idle_after_batch", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int         cnt;
    int         cyc;
    logic       seen;
    logic [3:0] mask;
    logic [63:0] words;

    rst  = 1'b1;
    req  = '0;
    data = '0;
    repeat (3) step();
    chk("rst_pipe_req", 32'(pipe_req), 32'd0);
    chk("rst_pipe_data", 32'(pipe_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    // Single transfer, instant pipeline: exact cycle timing.
    ack_mode = 2'd0;
    ack_dly  = 3'd0;
    words    = 64'h0000_0000_0000_A5A5;
    plan(4'b0001, words);
    data = words;
    req  = 4'b0001;
    for (int c = 0; c <= DONE_C; c++) begin
      step();
      chk($sformatf("timing_pipe_req_c%0d", c), 32'(pipe_req),
          32'((c >= RISE_C) && (c < FALL_C)));
      chk($sformatf("timing_busy_c%0d", c), 32'(busy), 32'(c < DONE_C));
      chk($sformatf("timing_done_c%0d", c), 32'(done), (c == DONE_C) ? 32'd1 : 32'd0);
      if (c == 0) chk("setup_data", 32'(pipe_data), 32'h0000_A5A5);
    end
    drain("single_complete", 10);

    // Fairness from a fresh pointer: 0,1,2,3 then 0.
    do_reset(2);
    run_batch(4'b1111, 64'h4444_3333_2222_1111, 3'd3);
    run_batch(4'b0001, 64'h4444_3333_2222_1111, 3'd3);

    // Pointer wrap: serve 2, then {3,0} is served 3 then 0.
    run_batch(4'b0100, 64'h0000_BEEF_0000_0000, 3'd1);
    run_batch(4'b1001, 64'hC0DE_0000_0000_F00D, 3'd2);

    // Random batches.
    repeat (20) begin
      mask  = 4'($urandom_range(1, 15));
      words = {$urandom, $urandom};
      run_batch(mask, words, 3'($urandom_range(0, 4)));
    end

    // Timeout: ack never arrives.
    do_reset(2);
    ack_mode = 2'd1;
    plan(4'b0001, 64'h0000_0000_0000_1234);
    done_q.delete();
    data = 64'h0000_0000_0000_1234;
    req  = 4'b0001;
    cnt  = 0;
    cyc  = 0;
    while (!err && cyc < 300) begin
      step();
      if (pipe_req) cnt++;
      cyc++;
    end
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_ph_up_cycles", 32'(cnt), 32'(TO));
    chk("timeout_pipe_req", 32'(pipe_req), 32'd0);
    repeat (5) step();
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_no_req", 32'(pipe_req), 32'd0);
    chk("err_busy", 32'(busy), 32'd1);
    do_reset(1);
    chk("rst_clears_err", 32'(err), 32'd0);
    chk("rst_clears_busy", 32'(busy), 32'd0);

    // Ack stuck high: no grant until it returns to zero.
    ack_mode = 2'd2;
    do_reset(2);
    repeat (3) step();
    data = 64'h0000_0000_7777_0000;
    req  = 4'b0010;
    seen = 1'b0;
    repeat (8) begin
      step();
      seen = seen | busy | pipe_req;
    end
    chk("ack_high_no_grant", 32'(seen), 32'd0);
    plan(4'b0010, 64'h0000_0000_7777_0000);
    ack_mode = 2'd0;
    ack_dly  = 3'd0;
    step();
    chk("ack_release_c1_busy", 32'(busy), 32'd0);
    step();
    chk("ack_release_c2_busy", 32'(busy), 32'd0);
    step();
    chk("ack_release_c3_busy", 32'(busy), 32'd1);
    chk("ack_release_grant", 32'(grant_id), 32'd1);
    drain("ack_release_complete", 40);

    // Reset in the middle of PH_UP.
    do_reset(2);
    ack_mode = 2'd0;
    ack_dly  = 3'd3;
    plan(4'b0001, 64'h0000_0000_0000_9999);
    done_q.delete();
    data = 64'h0000_0000_0000_9999;
    req  = 4'b0001;
    cyc  = 0;
    while (!pipe_req && cyc < 10) begin
      step();
      cyc++;
    end
    chk("midrst_reached_ph_up", 32'(pipe_req), 32'd1);
    step();
    rst = 1'b1;
    step();
    chk("midrst_pipe_req", 32'(pipe_req), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_grant_id", 32'(grant_id), 32'd0);
    chk("midrst_pipe_data", 32'(pipe_data), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    rst = 1'b0;
    req = '0;
    launch_q.delete();
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_pipe_arbiter.md
# hs_pipe_arbiter

Synchronous round-robin arbiter that shares the input port of the `four_phase_hand` three-stage handshake pipeline among N clocked requesters. It grants one requester at a time, launches that requester's word into the pipeline with a bundled-data four-phase (return-to-zero) handshake, and pulses a completion strobe back to the requester. It sits at the clocked/asynchronous boundary. The pipeline's stage-1 acknowledge returns through an internal synchronizer, and a watchdog flags a pipeline that stops acknowledging.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `W`, default 16: data width; matches the pipeline data path.
- `SYNC_STAGES`, default 2: flops in the ack synchronizer, minimum 2.
- `TIMEOUT`, default 64: maximum cycles spent in either handshake phase before error.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  level request per requester; held until its `done` pulse.
- `data`  in  N*W  requester words; slice i is `data[i*W +: W]`; held while `req[i]` is high.
- `done`  out  N  one-cycle pulse to the granted requester on handshake completion.
- `grant_id`  out  $clog2(N)  index of the current or last granted requester.
- `busy`  out  1  high in any state other than IDLE.
- `pipe_req`  out  1  drives pipeline `in_req`; registered.
- `pipe_data`  out  W  drives pipeline `in_data`; registered.
- `pipe_ack`  in  1  pipeline `out_ack` (stage-1 C-element output); asynchronous to `clk`.
- `err`  out  1  sticky timeout flag; cleared only by `rst`.

## Operation
- `ack_s` is `pipe_ack` after the `SYNC_STAGES` flop synchronizer.
- States: IDLE, SETUP, PH_UP, PH_DN, ERR.
- **IDLE:** if `|req` and `ack_s==0`, select the winner and go to SETUP.
  - Winner is the first set bit at or after `rr_ptr`, searching cyclically (wrap N-1 to 0).
  - On transition, load `pipe_data` with the winner's slice and `grant_id` with the winner index.
  - If `ack_s==1`, stay in IDLE: the pipeline has not returned to zero.
- **SETUP:** one cycle, `pipe_req` low, data stable. Then go to PH_UP and set `pipe_req=1`. This gives the bundled-data setup margin.
- **PH_UP:** hold `pipe_req=1`. When `ack_s==1`, clear `pipe_req` and go to PH_DN.
- **PH_DN:** hold `pipe_req=0`. When `ack_s==0`:
  - pulse `done[grant_id]`;
  - set `rr_ptr = grant_id+1` (mod N);
  - return to IDLE.
- **Data hold:** `pipe_data` is constant from SETUP through the end of PH_DN, and holds its last value in IDLE.
- **Watchdog:** `wd_cnt` clears on entry to PH_UP and to PH_DN, and increments every cycle in those states. If `wd_cnt==TIMEOUT-1` and the awaited `ack_s` level has not arrived, go to ERR.
- **ERR:** `pipe_req=0`, `err=1`, no grants, no `done`. Exit only by `rst`.
- **Requester dropping `req` mid-transfer:** ignored. The handshake completes and `done` still pulses.
- **New `req` arriving during a transfer:** queued implicitly and considered at the next IDLE.

## Timing
- **Reset values:**
  - state IDLE;
  - `pipe_req=0`, `pipe_data=0`, `done=0`, `grant_id=0`, `busy=0`, `err=0`;
  - `rr_ptr=0`, synchronizer flops 0, `wd_cnt=0`.
- **Reset mid-handshake:** `pipe_req` is 0 at the next edge. After reset, IDLE waits for `ack_s==0` before any new grant.
- **Grant latency:** `req` sampled high at edge 0 gives SETUP after edge 0 and `pipe_req=1` after edge 1.
- **Handshake latency:** with an instant pipeline, `pipe_req` rises at edge 1 and falls at edge 1+SYNC_STAGES+1. `done` pulses SYNC_STAGES+1 cycles after that.
  - Minimum throughput for SYNC_STAGES=2 is one word per 8 cycles.
- **Same-cycle events:** when `req` is asserted in the same cycle as `done` to another requester, the new request is evaluated in IDLE on the next cycle. No grant is issued in the `done` cycle.
- **Outputs:** all are registered; no combinational path from `req` or `pipe_ack` to any output.

## Structure
- Package `hs_pkg`:
  - state enum `hs_arb_state_t` (IDLE, SETUP, PH_UP, PH_DN, ERR);
  - default parameter constants `HS_W=16`, `HS_SYNC=2`, `HS_TIMEOUT=64`.
- Sub-module `hs_sync`: parameterised N-flop single-bit synchronizer with synchronous reset to 0. It is instantiated once for `pipe_ack`.
- Round-robin selection is a combinational function inside `hs_pipe_arbiter`. Default parameters apply unless stated.

## Test plan
- **Single transfer:** `req=4'b0001`, `data[15:0]=16'hA5A5`, with a behavioural pipeline model where ack follows req after 3 cycles. Expect `pipe_data=16'hA5A5` before `pipe_req` rises, one `done[0]` pulse, then `busy=0`.
- **Fairness:** all four `req` held high, words 0x1111/0x2222/0x3333/0x4444. Grant order is 0,1,2,3,0. `done` pulses in that order, and each requester is served once per 4 transfers.
- **Pointer wrap:** `rr_ptr=3` after serving requester 2, then `req=4'b1001`. Requester 3 is granted, then requester 0.
- **Timeout:** the pipeline model never raises ack. `err=1` and `pipe_req=0` once PH_UP has lasted 64 cycles, with no `done` pulse. `rst` clears `err`.
- **Ack stuck high:** hold `pipe_ack=1` at reset release with `req=4'b0010`. No grant while ack is high. Release ack; requester 1 is granted 2+1 cycles later.
- **Reset mid-transfer:** assert `rst` during PH_UP. `pipe_req=0` at the next edge, no `done` pulse, and all outputs at reset values.
